// File: rtl/tdm_demux_if.sv
// tdm_demux_if: slot-interleaved link bundle between a TDM source and tdm_demux.
//   in_valid/in_sof/in_data  : one slot beat per valid cycle, in_sof marks slot 0
//   out_valid/out_data       : completed frame, channel k at out_data[k*W +: W]
//   out_err                  : partial frame discarded
//   modport master drives the beats; modport slave is the demultiplexer side.
interface tdm_demux_if #(
    parameter int N_CH = 4,
    parameter int W    = 8
);
    logic            in_valid;
    logic            in_sof;
    logic [W-1:0]    in_data;
    logic            out_valid;
    logic [N_CH*W-1:0] out_data;
    logic            out_err;
    modport master (output in_valid, in_sof, in_data, input out_valid, out_data, out_err);
    modport slave  (input in_valid, in_sof, in_data, output out_valid, out_data, out_err);
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: rebuilds N_CH-slot TDM frames from a shared beat path into one aligned word.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : tdm_demux_if.slave (beats in, frame/err pulses out)
//   Optional macro TDM_DEMUX_TIMEOUT_EN: abandon a frame after TIMEOUT idle cycles.
module tdm_demux #(
    parameter int N_CH    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux_if.slave   bus
);
    localparam int SW = $clog2(N_CH);

    typedef enum logic {IDLE, COLLECT} state_t;

    if (N_CH < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("tdm_demux: N_CH must be >= 2 and TIMEOUT >= 1");
    end

    state_t                r_state, w_state_nx;
    logic [SW-1:0]         r_slot, w_slot_nx;
    logic [(N_CH-1)*W-1:0] r_stage;
    logic                  w_start, w_last, w_mid, w_err, w_tmo;

`ifdef TDM_DEMUX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_idle;
    // Fires on the TIMEOUT-th consecutive idle cycle; a beat in that cycle wins.
    assign w_tmo = (r_state == COLLECT) && !bus.in_valid && (r_idle == TW'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (!rst_n || r_state != COLLECT || bus.in_valid || w_tmo)
            r_idle <= '0;
        else
            r_idle <= r_idle + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        // A SOF beat always opens a new frame; in COLLECT it also discards the old one.
        w_start    = bus.in_valid && bus.in_sof;
        w_last     = (r_state == COLLECT) && bus.in_valid && !bus.in_sof && (r_slot == SW'(N_CH - 1));
        w_mid      = (r_state == COLLECT) && bus.in_valid && !bus.in_sof && !w_last;
        w_err      = ((r_state == COLLECT) && w_start) || w_tmo;
        w_state_nx = w_start ? COLLECT : (w_last || w_tmo) ? IDLE : r_state;
        w_slot_nx  = w_start ? SW'(1) : (w_last || w_tmo) ? '0 : w_mid ? r_slot + 1'b1 : r_slot;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_slot  <= w_slot_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stage       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            if (w_start)
                r_stage[0 +: W] <= bus.in_data;
            else if (w_mid)
                r_stage[r_slot*W +: W] <= bus.in_data;
            bus.out_valid <= w_last;
            bus.out_err   <= w_err;
            if (w_last)
                bus.out_data <= {bus.in_data, r_stage};
        end
    end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receiving end of a slot-interleaved link where a multiplexer places N channels onto one shared data path. It tracks slot position from a start-of-frame marker and steers each beat into its channel register. After a complete frame, it presents all channels at once as a single aligned word. It sits between the shared serial-slot path and per-channel consumers.

## Interface
- `N_CH`, 4, number of channels (slots per frame); legal range ≥ 2
- `W`, 8, data width per channel
- `TIMEOUT`, 16, idle-cycle limit inside a frame; used only with the timeout feature; legal range ≥ 1
- `clk` input 1 — single clock, all logic rising-edge
- `rst_n` input 1 — synchronous, active-low reset
- `in_valid` input 1 — beat present on `in_data` this cycle
- `in_sof` input 1 — qualifies a valid beat as slot 0 of a new frame; ignored when `in_valid`=0
- `in_data` input W — slot payload
- `out_valid` output 1 — one-cycle pulse, `out_data` holds a newly completed frame
- `out_data` output N_CH*W — channel k at `out_data[k*W +: W]`
- `out_err` output 1 — one-cycle pulse, partial frame discarded

## Operation
- Slot counter width is $clog2(N_CH). Staging registers hold N_CH-1 words (slots 0..N_CH-2).
- State IDLE (hunting for frame start):
  - `in_valid & in_sof`: store the beat to slot 0, set slot=1, go to COLLECT.
  - `in_valid & !in_sof`: drop the beat silently; no error.
- State COLLECT:
  - `in_valid & !in_sof` with slot < N_CH-1: store to staging[slot], slot++.
  - `in_valid & !in_sof` with slot = N_CH-1 (last slot):
    - `out_data` <= {in_data, staging} in a single update.
    - `out_valid` pulses.
    - Slot returns to 0; state returns to IDLE.
  - `in_valid & in_sof` (early SOF at any slot, including the last): `out_err` pulses and the partial frame is discarded. The beat is taken as slot 0 of a new frame: slot=1, stay in COLLECT. `out_data` is unchanged.
  - `in_valid`=0: hold state and slot.
- `out_data` changes only on frame completion. It holds its value across errors, idle periods and partial frames.
- Back-to-back frames are supported: a SOF beat on the cycle right after the last-slot beat starts the next frame with no bubble.
- Reset values:
  - `out_valid`=0, `out_err`=0, `out_data`=0.
  - State IDLE, slot=0, staging=0, timeout counter=0.
- Reset asserted mid-frame discards the partial frame with no `out_err`. The first beat after reset is accepted only if it carries SOF.

## Timing
- `out_valid` and `out_data` become visible one cycle after the clock edge that accepts the last-slot beat. Total latency from the SOF beat to `out_valid` is N_CH cycles with no gaps.
- `out_err` becomes visible one cycle after the edge that accepts the early-SOF beat, or after the edge where the timeout fires.
- `out_valid` and `out_err` never assert in the same cycle.
- There is no backpressure: every valid beat is consumed in its cycle.

## Configuration
- `TDM_DEMUX_TIMEOUT_EN` defined:
  - A counter counts consecutive COLLECT cycles with `in_valid`=0. It clears on any accepted beat and on entry to COLLECT.
  - When TIMEOUT consecutive idle cycles elapse, `out_err` pulses on the next cycle, the partial frame is discarded and state goes to IDLE.
  - A beat arriving on the expiry cycle is processed normally; the timeout does not fire.
- `TDM_DEMUX_TIMEOUT_EN` undefined:
  - No counter logic is present and the `TIMEOUT` parameter is unused.
  - COLLECT waits indefinitely for the next beat.

## Test plan
All scenarios use N_CH=4, W=8.
- Normal frame: SOF+0x11, then 0x22, 0x33, 0x44 on consecutive cycles -> `out_valid`=1 for one cycle, one cycle after 0x44; `out_data`=0x44332211; `out_err` stays 0.
- Gapped and back-to-back frames:
  - Frame 1 is 0xA0..0xA3 with 2 idle cycles between each beat.
  - Frame 2 starts with its SOF beat on the cycle after 0xA3.
  - Expected: two `out_valid` pulses with `out_data`=0xA3A2A1A0 then frame 2's value; no errors.
- Early SOF and pre-sync garbage:
  - Non-SOF 0xFF beats while in IDLE -> ignored, no error.
  - SOF+0x01, 0x02, then SOF+0x10, 0x20, 0x30, 0x40 -> `out_err` pulses once, one cycle after the second SOF.
  - Then `out_valid` with `out_data`=0x40302010, and the previous `out_data` is held in between.
- Reset mid-frame: SOF+0x55, 0x66, assert `rst_n`=0 for 1 cycle, then 0x77, 0x88 without SOF -> all outputs 0, no `out_valid`, no `out_err`.
- Timeout, with the macro defined and TIMEOUT=16:
  - SOF+0x01, then 16 idle cycles -> `out_err` pulse; a subsequent non-SOF beat is ignored.
  - Same stimulus with an idle gap of 15 cycles -> the frame completes normally.
  - Macro undefined, idle gap of 100 cycles -> the frame completes normally.
